// File: rtl/serial_header_decoder.sv
// serial_header_decoder: watches the serial line for a start bit, then shifts
// in a port address and a payload length (both MSB first). It then enables the
// downstream transmitter until that block reports done. Payload bits are not
// captured here; they pass on serIn directly to the transmitter.
module serial_header_decoder #(
  parameter int unsigned PORT_W = 2,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serIn,
  input  logic              done,
  output logic              en,
  output logic [LEN_W-1:0]  nt,
  output logic [PORT_W-1:0] port,
  output logic              busy
);

  localparam int unsigned MAX_W = (PORT_W > LEN_W) ? PORT_W : LEN_W;
  localparam int unsigned CNT_W = $clog2(MAX_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_LEN  = 2'd2,
    ST_SEND = 2'd3
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [PORT_W-1:0] port_q;
  logic [LEN_W-2:0]  len_q;
  logic [LEN_W-1:0]  nt_q;
  logic              en_q;
  logic              busy_q;

  // Shift values including the bit currently on the line.
  // The length register holds only the leading LEN_W-1 bits.
  // The final bit is merged here at the last length edge.
  logic [PORT_W-1:0] port_d;
  logic [LEN_W-1:0]  len_d;

  assign port_d = PORT_W'({port_q, serIn});
  assign len_d  = {len_q, serIn};

  // Header FSM with bit counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      port_q  <= '0;
      len_q   <= '0;
      nt_q    <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!serIn) begin
            state_q <= ST_ADDR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_ADDR: begin
          port_q <= port_d;
          if (cnt_q == CNT_W'(PORT_W - 1)) begin
            state_q <= ST_LEN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_LEN: begin
          len_q <= (LEN_W-1)'(len_d);
          if (cnt_q == CNT_W'(LEN_W - 1)) begin
            cnt_q <= '0;
            if (len_d != '0) begin
              nt_q    <= len_d;
              en_q    <= 1'b1;
              state_q <= ST_SEND;
            end else begin
              // Empty packet: nothing to send, resume start-bit search.
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_SEND: begin
          if (done) begin
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign en   = en_q;
  assign nt   = nt_q;
  assign port = port_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_serial_header_decoder.sv
// Bench for serial_header_decoder: directed scenarios followed by random packets.
// Expected values come from packet-level fields (port, length, done delay).
module tb_serial_header_decoder;

  localparam int unsigned PORT_W = 2;
  localparam int unsigned LEN_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              serIn = 1'b1;
  logic              done = 1'b0;
  logic              en;
  logic [LEN_W-1:0]  nt;
  logic [PORT_W-1:0] port;
  logic              busy;

  int          total = 0;
  int          bad = 0;
  int unsigned exp_port = 0;
  int unsigned exp_nt = 0;

  serial_header_decoder #(.PORT_W(PORT_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .serIn (serIn),
    .done  (done),
    .en    (en),
    .nt    (nt),
    .port  (port),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Idle expectations: nothing enabled, last header fields retained.
  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_en"},   32'(en),   32'd0);
    chk({tag, "_port"}, 32'(port), exp_port);
    chk({tag, "_nt"},   32'(nt),   exp_nt);
  endtask

  // Start bit, then address and length MSB first; checks the decode result.
  task automatic header(input int unsigned p, input int unsigned len);
    serIn = 1'b0;
    step();
    chk("s0_busy", 32'(busy), 32'd1);
    chk("s0_en", 32'(en), 32'd0);
    for (int i = PORT_W - 1; i >= 0; i--) begin
      serIn = p[i];
      step();
    end
    chk("addr_busy", 32'(busy), 32'd1);
    for (int i = LEN_W - 1; i >= 0; i--) begin
      serIn = len[i];
      step();
      if (i != 0) chk("len_en", 32'(en), 32'd0);
    end
    exp_port = p;
    if (len != 0) exp_nt = len;
    chk("hdr_port", 32'(port), exp_port);
    chk("hdr_nt",   32'(nt),   exp_nt);
    chk("hdr_en",   32'(en),   32'(len != 0));
    chk("hdr_busy", 32'(busy), 32'(len != 0));
    serIn = 1'b1;
  endtask

  // Payload phase: dly cycles without done, then one done edge.
  task automatic payload(input int unsigned dly, input bit zeros);
    for (int k = 0; k < int'(dly); k++) begin
      serIn = zeros ? 1'b0 : 1'($urandom_range(0, 1));
      done = 1'b0;
      step();
      chk("send_en",   32'(en),   32'd1);
      chk("send_busy", 32'(busy), 32'd1);
      chk("send_nt",   32'(nt),   exp_nt);
      chk("send_port", 32'(port), exp_port);
    end
    serIn = zeros ? 1'b0 : 1'($urandom_range(0, 1));
    done = 1'b1;
    step();
    done = 1'b0;
    serIn = 1'b1;
    check_idle("after_done");
  endtask

  // Assert reset between edges and confirm outputs clear before the next edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    exp_port = 0;
    exp_nt = 0;
    check_idle(tag);
    step();
    check_idle({tag, "_held"});
    rst = 1'b1;
    serIn = 1'b1;
    step();
    check_idle({tag, "_rel"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned rp, rl, rd, gap;

    // Reset held with the line toggling.
    for (int c = 0; c < 3; c++) begin
      serIn = ~serIn;
      step();
      check_idle("reset");
    end
    rst = 1'b1;
    serIn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check_idle("idle_line_high");
    end

    // Basic packet: port 2, length 5, done five cycles later.
    header(2, 5);
    payload(5, 1'b0);

    // All-zero payload must not look like a start bit.
    header(1, 8);
    payload(12, 1'b1);
    step();
    check_idle("zero_payload_no_restart");

    // Zero length: no enable, and the next edge accepts a start bit.
    header(3, 0);
    header(1, 3);
    payload(2, 1'b0);
    // Back-to-back: second start bit right after done.
    header(0, 255);
    payload(255, 1'b0);

    // Reset during length bit 4.
    serIn = 1'b0;
    step();
    for (int i = 0; i < int'(PORT_W); i++) begin
      serIn = 1'b1;
      step();
    end
    for (int i = 0; i < 4; i++) begin
      serIn = 1'($urandom_range(0, 1));
      step();
    end
    chk("mid_len_busy", 32'(busy), 32'd1);
    async_reset("rst_mid_len");

    // Reset during SEND.
    header(2, 7);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("pre_rst_en", 32'(en), 32'd1);
    end
    async_reset("rst_mid_send");

    // Clean packet after reset.
    header(3, 9);
    payload(3, 1'b0);

    // Random packets with random gaps and done delays.
    for (int n = 0; n < 30; n++) begin
      rp = $urandom_range(0, (1 << PORT_W) - 1);
      case ($urandom_range(0, 5))
        0:       rl = 0;
        1:       rl = 255;
        2:       rl = 1;
        default: rl = $urandom_range(0, 255);
      endcase
      rd = $urandom_range(0, 6);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < int'(gap); g++) begin
        serIn = 1'b1;
        step();
        check_idle("rand_gap");
      end
      header(rp, rl);
      if (rl != 0) payload(rd, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
